tdm_demux: RTL
==============

# tdm_demux

Time-division demultiplexer: the receive-side counterpart of the team's 2:1/N:1 channel muxes. It takes one interleaved sample stream, where a transmitter selects each channel in turn and marks slot 0 with a frame sync. It then steers each sample into its own per-channel output register with a per-channel valid strobe. A small lock state machine and a slot counter track frame alignment, realign on an early sync, and flag the error.

## Interface
Parameters:
- N_CH, 4: number of channels (slots per frame); legal range 2..16.
- WIDTH, 8: bits per sample.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state and outputs.
- din  input  WIDTH  sample for the current slot.
- din_valid  input  1  din is a real beat this cycle; the slot advances only on valid beats.
- frame_sync  input  1  this beat is slot 0; ignored unless din_valid=1.
- dout  output  N_CH*WIDTH  channel c's sample is at dout[c*WIDTH +: WIDTH]; registered.
- dout_valid  output  N_CH  bit c pulses for one cycle when channel c is updated.
- frame_done  output  1  one-cycle pulse when slot N_CH-1 is captured.
- sync_err  output  1  one-cycle pulse when frame_sync arrives at a nonzero slot.
- locked  output  1  state is LOCKED.

## Operation
- Slot counter width: $clog2(N_CH). It counts 0..N_CH-1 and wraps to 0 after N_CH-1.
- States:
  - HUNT: the reset state.
  - LOCKED.
- HUNT behaviour:
  - Beats without frame_sync are discarded: no capture, no strobe.
  - A beat with din_valid=1 and frame_sync=1 is captured into channel 0. slot becomes 1 and the state becomes LOCKED.
- LOCKED, on each din_valid=1 beat:
  - No frame_sync, or frame_sync with slot==0: capture din into channel slot and pulse dout_valid[slot].
  - If that slot was N_CH-1, also pulse frame_done and set slot to 0; otherwise slot+1.
  - Missing frame_sync at slot 0 is legal (flywheel): the capture proceeds normally with no error.
  - frame_sync with slot!=0: resync. Capture into channel 0, pulse dout_valid[0] and sync_err, and set slot to 1. No frame_done is issued for the truncated frame.
- din_valid=0: nothing changes, the strobes are 0, and frame_sync is ignored.
- Channels not being written hold their last value. dout is never cleared except by rst.
- Exactly one dout_valid bit is high on any capture cycle; all are zero otherwise.
- There is no path back to HUNT except rst.

## Timing
- Reset values:
  - dout = 0, dout_valid = 0, frame_done = 0, sync_err = 0, locked = 0.
  - state = HUNT, slot = 0.
- Reset acts immediately, asynchronously, including mid-frame. The first post-reset frame must again present frame_sync.
- Latency: one cycle. A beat sampled at edge k makes its dout slice, dout_valid bit, frame_done and sync_err visible after edge k, for exactly one cycle (the strobes).
- locked rises after the edge that samples the first sync beat, in the same cycle as dout_valid[0].
- Throughput: one sample per clock; back-to-back valid beats are fully supported.
- frame_done coincides with dout_valid[N_CH-1]. sync_err coincides with dout_valid[0].
- All outputs come directly from registers; there is no combinational input-to-output path.

## Test plan
All scenarios use N_CH=4 and WIDTH=8.

- Reset, then 3 beats with frame_sync=0 -> locked=0, dout=0, no strobes.
- Sync beat 0x11 followed by 0x22, 0x33, 0x44, all back-to-back -> dout_valid=0001, 0010, 0100, 1000 on successive cycles. frame_done is high with 1000. dout=0x44332211, locked=1.
- Second frame 0xA0..0xA3 with frame_sync=0 on its first beat, and din_valid gaps inserted -> still captured in order, no sync_err, frame_done on 0xA3, dout=0xA3A2A1A0.
- While locked, after two beats 0xB0, 0xB1 of a frame, a beat 0xC0 with frame_sync=1 -> sync_err and dout_valid[0] pulse together. Channel 0 = 0xC0, slot=1, no frame_done. The next three beats land in channels 1..3 with frame_done.
- Assert rst mid-frame (slot=2) -> all outputs 0 immediately with no clock edge. Subsequent beats without sync are ignored until a sync beat.
- frame_sync=1 with din_valid=0 at slot 2 -> no sync_err and no state change.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: steers an interleaved sample stream into
// per-channel registers, tracking frame alignment with a lock FSM and slot counter.
//
// state  | meaning
// HUNT   | waiting for the first frame_sync beat; non-sync beats are dropped
// LOCKED | aligned; every valid beat is captured into the current slot
`timescale 1ns/1ps
module tdm_demux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [N_CH*WIDTH-1:0] dout,
    output logic [N_CH-1:0]       dout_valid,
    output logic                  frame_done,
    output logic                  sync_err,
    output logic                  locked
);

    localparam int SW = $clog2(N_CH);
    localparam logic [SW-1:0]   LP_LAST = SW'(N_CH - 1);
    localparam logic [N_CH-1:0] LP_ONE  = N_CH'(1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_slot;
    logic [SW-1:0]         w_slot_nxt;
    logic                  w_cap;
    logic [SW-1:0]         w_cap_slot;
    logic                  w_done;
    logic                  w_err;

    logic [N_CH*WIDTH-1:0] r_dout;
    logic [N_CH-1:0]       r_dout_valid;
    logic                  r_frame_done;
    logic                  r_sync_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_cap       = 1'b0;
        w_cap_slot  = '0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            HUNT: begin
                if (din_valid && frame_sync) begin
                    w_cap       = 1'b1;
                    w_slot_nxt  = SW'(1);
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    w_cap = 1'b1;
                    // An early sync truncates the current frame and restarts at slot 0
                    if (frame_sync && (r_slot != '0)) begin
                        w_err      = 1'b1;
                        w_slot_nxt = SW'(1);
                    end else begin
                        w_cap_slot = r_slot;
                        if (r_slot == LP_LAST) begin
                            w_done     = 1'b1;
                            w_slot_nxt = '0;
                        end else begin
                            w_slot_nxt = r_slot + SW'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_cap && (w_cap_slot == SW'(c)))
                    r_dout[c*WIDTH +: WIDTH] <= din;
            end
            r_dout_valid <= w_cap ? (LP_ONE << w_cap_slot) : '0;
            r_frame_done <= w_done;
            r_sync_err   <= w_err;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign locked     = (r_state == LOCKED);

endmodule
